gpu_bg_block_cache: RTL

Parametrised background block cache for the GPU back end. It accumulates LANES pixels per cycle into one VRAM block of BLOCK_PIX 16-bit pixels. It loads the block from DDR only when blending or mask-check needs it, merges loaded data under the written-pixel mask, and saves the block with a valid/ready handshake. It sits between the per-lane pixel compute stage and the DDR arbiter, and adds the PSX mask-bit check/force modes.

---
 rtl/gpu_bg_block_cache.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/gpu_bg_block_cache.sv
// Background block cache: gathers LANES-wide pixel groups into one VRAM block,
// loads destination content on demand, applies PSX mask check/force and saves the block.
module gpu_bg_block_cache #(
    parameter int LANES     = 2,
    parameter int BLOCK_PIX = 16,
    parameter int PIX_W     = 16,
    parameter int ADR_W     = 15,
    parameter int SLOT_W    = (BLOCK_PIX / LANES > 1) ? $clog2(BLOCK_PIX / LANES) : 1
) (
    input  logic                       clk,
    input  logic                       i_nrst,
    input  logic                       i_pix_valid,
    output logic                       o_pix_ready,
    input  logic [ADR_W-1:0]           i_blk_adr,
    input  logic [SLOT_W-1:0]          i_slot,
    input  logic [LANES-1:0]           i_lane_en,
    input  logic [LANES*PIX_W-1:0]     i_pix_data,
    input  logic                       i_need_bg,
    input  logic                       i_check_mask,
    input  logic                       i_force_mask,
    input  logic                       i_flush,
    output logic [LANES*PIX_W-1:0]     o_bg_pix,
    output logic                       o_load_req,
    output logic [ADR_W-1:0]           o_load_adr,
    input  logic                       i_load_ack,
    input  logic [BLOCK_PIX*PIX_W-1:0] i_load_data,
    output logic                       o_save_valid,
    input  logic                       i_save_ready,
    output logic [ADR_W-1:0]           o_save_adr,
    output logic [BLOCK_PIX*PIX_W-1:0] o_save_data,
    output logic [BLOCK_PIX-1:0]       o_save_mask,
    output logic                       o_busy
);
    localparam int IDX_W = (BLOCK_PIX > 1) ? $clog2(BLOCK_PIX) : 1;

    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_OPEN, S_SAVE} state_t;

    state_t               state_q, state_d;
    logic [ADR_W-1:0]     adr_q;
    logic [BLOCK_PIX-1:0] mask_q;
    logic                 loaded_q;
    logic [PIX_W-1:0]     cache_q [BLOCK_PIX];

    logic                 need_load, match;
    logic                 pix_ready, adr_latch, do_write, do_merge, do_release;
    logic [IDX_W-1:0]     lane_idx [LANES];
    logic [LANES-1:0]     wr_en;
    logic [PIX_W-1:0]     wr_word [LANES];

    assign need_load = i_need_bg | i_check_mask;
    assign match     = (i_blk_adr == adr_q);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pix_ready  = 1'b0;
        adr_latch  = 1'b0;
        do_write   = 1'b0;
        do_merge   = 1'b0;
        do_release = 1'b0;
        case (state_q)
            S_EMPTY: begin
                pix_ready = i_pix_valid & ~need_load & ~i_flush;
                if (i_pix_valid && need_load) begin
                    adr_latch = 1'b1;
                    state_d   = S_LOAD;
                end else if (pix_ready) begin
                    adr_latch = 1'b1;
                    do_write  = 1'b1;
                    state_d   = S_OPEN;
                end
            end
            S_LOAD: begin
                if (i_load_ack) begin
                    do_merge = 1'b1;
                    state_d  = S_OPEN;
                end
            end
            S_OPEN: begin
                // Flush or a foreign address closes the block before any write.
                if (i_flush || (i_pix_valid && !match)) begin
                    if (|mask_q) begin
                        state_d = S_SAVE;
                    end else begin
                        do_release = 1'b1;
                        state_d    = S_EMPTY;
                    end
                end else if (i_pix_valid && need_load && !loaded_q) begin
                    state_d = S_LOAD;
                end else begin
                    pix_ready = i_pix_valid;
                    do_write  = i_pix_valid;
                end
            end
            S_SAVE: begin
                if (i_save_ready) begin
                    do_release = 1'b1;
                    state_d    = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = IDX_W'(i_slot) * IDX_W'(LANES) + IDX_W'(l);
            // A destination pixel with its mask bit set is protected under mask check.
            wr_en[l]    = do_write & i_lane_en[l] &
                          ~(i_check_mask & cache_q[lane_idx[l]][PIX_W-1]);
            wr_word[l]  = i_pix_data[l*PIX_W +: PIX_W] | {i_force_mask, {(PIX_W-1){1'b0}}};
            o_bg_pix[l*PIX_W +: PIX_W] = cache_q[lane_idx[l]];
        end
    end

    always_comb begin
        for (int k = 0; k < BLOCK_PIX; k++) begin
            o_save_data[k*PIX_W +: PIX_W] = cache_q[k];
        end
    end

    // NOTE: the block storage is reset too, so a freshly reset cache reads back as zero.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q  <= S_EMPTY;
            adr_q    <= '0;
            mask_q   <= '0;
            loaded_q <= 1'b0;
            for (int k = 0; k < BLOCK_PIX; k++) cache_q[k] <= '0;
        end else begin
            state_q <= state_d;
            if (adr_latch) adr_q <= i_blk_adr;
            if (do_release) begin
                mask_q   <= '0;
                loaded_q <= 1'b0;
            end
            if (do_merge) begin
                loaded_q <= 1'b1;
                for (int k = 0; k < BLOCK_PIX; k++) begin
                    if (!mask_q[k]) cache_q[k] <= i_load_data[k*PIX_W +: PIX_W];
                end
            end
            for (int l = 0; l < LANES; l++) begin
                if (wr_en[l]) begin
                    cache_q[lane_idx[l]] <= wr_word[l];
                    mask_q[lane_idx[l]]  <= 1'b1;
                end
            end
        end
    end

    assign o_pix_ready  = pix_ready;
    assign o_load_req   = (state_q == S_LOAD);
    assign o_load_adr   = adr_q;
    assign o_save_valid = (state_q == S_SAVE);
    assign o_save_adr   = adr_q;
    assign o_save_mask  = mask_q;
    assign o_busy       = (state_q != S_EMPTY);
endmodule
